// File: rtl/fetch_control.sv
// Fetch/pipeline controller: selects the PC source, flushes/stalls F/D, handles
// HLT, RET return-wait, load-use hazards and synchronized external interrupt injection.
module fetch_control #(
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e_valid,
    input  logic       e_hlt,
    input  logic       e_call,
    input  logic       e_int,
    input  logic       e_ret,
    input  logic [2:0] e_branch,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_c,
    input  logic       e_load,
    input  logic [2:0] e_rd,
    input  logic       d_valid,
    input  logic [2:0] d_rs1,
    input  logic [2:0] d_rs2,
    input  logic       d_use1,
    input  logic       d_use2,
    input  logic       m_ret_done,
    input  logic       irq,
    output logic [1:0] pc_sel,
    output logic       flush_fd,
    output logic       stall_fd,
    output logic       inject_int,
    output logic       irq_ack,
    output logic       halted
);

    localparam int unsigned SYNC_W = (IRQ_SYNC_STAGES < 2) ? 2 : IRQ_SYNC_STAGES;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        HALT     = 2'b01,
        RET_WAIT = 2'b10,
        INT_WAIT = 2'b11
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SYNC_W-1:0] irq_sync;
    logic              irq_prev;
    logic              irq_rise;
    logic              irq_pend;
    logic              irq_pend_next;
    logic              requeue;
    logic              lu_stalled;
    logic              lu_stall;
    logic              cc_true;
    logic              taken;
    logic              call_v;
    logic              int_v;
    logic              hlt_v;
    logic              ret_v;
    logic              hazard;

    // irq synchronizer and edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync <= '0;
            irq_prev <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[SYNC_W-2:0], irq};
            irq_prev <= irq_sync[SYNC_W-1];
        end
    end

    assign irq_rise = irq_sync[SYNC_W-1] & ~irq_prev;

    always_comb begin
        case (e_branch[1:0])
            2'b00:   cc_true = 1'b1;
            2'b01:   cc_true = flag_z;
            2'b10:   cc_true = flag_n;
            default: cc_true = flag_c;
        endcase
    end

    assign taken  = e_valid & e_branch[2] & cc_true;
    assign call_v = e_valid & e_call;
    assign int_v  = e_valid & e_int;
    assign hlt_v  = e_valid & e_hlt;
    assign ret_v  = e_valid & e_ret;
    // a load-use stall is only ever taken for one cycle in a row
    assign hazard = e_valid & e_load & d_valid & ~lu_stalled &
                    ((d_use1 & (d_rs1 == e_rd)) | (d_use2 & (d_rs2 == e_rd)));

    // Next-state and combinational outputs; all forced low while in reset
    always_comb begin
        state_next = state;
        pc_sel     = 2'b00;
        flush_fd   = 1'b0;
        stall_fd   = 1'b0;
        inject_int = 1'b0;
        irq_ack    = 1'b0;
        requeue    = 1'b0;
        lu_stall   = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (hlt_v) begin
                        flush_fd   = 1'b1;
                        state_next = HALT;
                    end else if (ret_v) begin
                        flush_fd   = 1'b1;
                        stall_fd   = 1'b1;
                        state_next = RET_WAIT;
                    end else if (int_v) begin
                        pc_sel   = 2'b11;
                        flush_fd = 1'b1;
                    end else if (taken | call_v) begin
                        pc_sel   = 2'b01;
                        flush_fd = 1'b1;
                    end else if (hazard) begin
                        stall_fd = 1'b1;
                        lu_stall = 1'b1;
                    end else if (irq_pend) begin
                        inject_int = 1'b1;
                        irq_ack    = 1'b1;
                        state_next = INT_WAIT;
                    end
                end
                RET_WAIT: begin
                    if (m_ret_done) begin
                        pc_sel     = 2'b10;
                        flush_fd   = 1'b1;
                        state_next = RUN;
                    end else begin
                        stall_fd = 1'b1;
                    end
                end
                INT_WAIT: begin
                    // an older redirect kills the injected INT, so it is requeued
                    if (int_v) begin
                        pc_sel     = 2'b11;
                        flush_fd   = 1'b1;
                        state_next = RUN;
                    end else if (ret_v) begin
                        flush_fd   = 1'b1;
                        stall_fd   = 1'b1;
                        requeue    = 1'b1;
                        state_next = RET_WAIT;
                    end else if (taken | call_v) begin
                        pc_sel     = 2'b01;
                        flush_fd   = 1'b1;
                        requeue    = 1'b1;
                        state_next = RUN;
                    end else if (hazard) begin
                        stall_fd = 1'b1;
                        lu_stall = 1'b1;
                    end
                end
                HALT: begin
                    if (irq_pend) begin
                        inject_int = 1'b1;
                        irq_ack    = 1'b1;
                        state_next = INT_WAIT;
                    end else begin
                        stall_fd = 1'b1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign irq_pend_next = (irq_pend & ~irq_ack) | irq_rise | requeue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            irq_pend   <= 1'b0;
            lu_stalled <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_next;
            irq_pend   <= irq_pend_next;
            lu_stalled <= lu_stall;
            halted     <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: per-cycle expected outputs are queued with
// the stimulus and compared on the falling edge.
module tb_fetch_control;

    localparam int unsigned S = 2;

    logic       clk;
    logic       rst_n;
    logic       e_valid, e_hlt, e_call, e_int, e_ret, e_load;
    logic [2:0] e_branch, e_rd, d_rs1, d_rs2;
    logic       flag_z, flag_n, flag_c;
    logic       d_valid, d_use1, d_use2, m_ret_done, irq;
    logic [1:0] pc_sel;
    logic       flush_fd, stall_fd, inject_int, irq_ack, halted;

    int         checks = 0;
    int         errors = 0;
    int         ack_cnt = 0;
    int         vec_cnt = 0;
    int         ack0, vec0;
    string      tag_q[$];
    logic [6:0] exp_q[$];
    string      mon_tag;
    logic [6:0] mon_exp;

    fetch_control #(.IRQ_SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_valid(e_valid), .e_hlt(e_hlt), .e_call(e_call), .e_int(e_int),
        .e_ret(e_ret), .e_branch(e_branch),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .e_load(e_load), .e_rd(e_rd),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use1(d_use1), .d_use2(d_use2),
        .m_ret_done(m_ret_done), .irq(irq),
        .pc_sel(pc_sel), .flush_fd(flush_fd), .stall_fd(stall_fd),
        .inject_int(inject_int), .irq_ack(irq_ack), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_sel, flush_fd, stall_fd, inject_int, irq_ack, halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // expected {pc_sel, flush, stall, inject, ack, halted} for the current cycle
    task automatic push(input string tag, input logic [1:0] pc, input logic fl,
                        input logic st, input logic inj, input logic ack, input logic h);
        tag_q.push_back(tag);
        exp_q.push_back({pc, fl, st, inj, ack, h});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        e_valid = 0; e_hlt = 0; e_call = 0; e_int = 0; e_ret = 0; e_load = 0;
        e_branch = 3'b000; e_rd = 3'd0; flag_z = 0; flag_n = 0; flag_c = 0;
        d_valid = 0; d_rs1 = 3'd0; d_rs2 = 3'd0; d_use1 = 0; d_use2 = 0;
        m_ret_done = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_tag = tag_q.pop_front();
            mon_exp = exp_q.pop_front();
            check(mon_tag, 32'(outs()), 32'(mon_exp));
        end
        if (irq_ack) ack_cnt++;
        if (pc_sel == 2'b11) vec_cnt++;
    end

    initial begin
        rst_n = 0; irq = 0;
        idle();
        // reset forces outputs low even with a jump in E
        tick(); e_valid = 1; e_branch = 3'b100; push("rst_jmp", 2'b00, 0, 0, 0, 0, 0);
        tick(); idle(); rst_n = 1; push("rst_rel", 2'b00, 0, 0, 0, 0, 0);

        // branch conditions
        tick(); e_valid = 1; e_branch = 3'b101; flag_z = 1; push("jz_t", 2'b01, 1, 0, 0, 0, 0);
        tick(); flag_z = 0; push("jz_nt", 2'b00, 0, 0, 0, 0, 0);
        tick(); e_branch = 3'b100; push("jmp", 2'b01, 1, 0, 0, 0, 0);
        tick(); e_branch = 3'b110; flag_n = 1; push("jn_t", 2'b01, 1, 0, 0, 0, 0);
        tick(); flag_n = 0; flag_c = 1; push("jn_nt", 2'b00, 0, 0, 0, 0, 0);
        tick(); e_valid = 0; e_branch = 3'b100; push("jmp_inv", 2'b00, 0, 0, 0, 0, 0);
        tick(); idle(); e_valid = 1; e_call = 1; push("call", 2'b01, 1, 0, 0, 0, 0);

        // load-use hazard
        tick(); idle(); e_valid = 1; e_load = 1; e_rd = 3'd3; d_valid = 1; d_rs2 = 3'd3; d_use2 = 1;
        push("lu_stall", 2'b00, 0, 1, 0, 0, 0);
        tick(); push("lu_once", 2'b00, 0, 0, 0, 0, 0);
        tick(); d_use2 = 0; push("lu_nouse", 2'b00, 0, 0, 0, 0, 0);
        tick(); d_use1 = 1; d_rs1 = 3'd3; push("lu_rs1", 2'b00, 0, 1, 0, 0, 0);
        tick(); idle(); push("idle1", 2'b00, 0, 0, 0, 0, 0);
        tick(); e_valid = 1; e_load = 1; e_rd = 3'd3; d_valid = 1; d_rs2 = 3'd3; d_use2 = 1;
        e_branch = 3'b111; flag_c = 1; push("lu_jc", 2'b01, 1, 0, 0, 0, 0);

        // return wait
        tick(); idle(); e_valid = 1; e_ret = 1; push("ret", 2'b00, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); push("ret_wait", 2'b00, 0, 1, 0, 0, 0);
        end
        tick(); m_ret_done = 1; push("ret_done", 2'b10, 1, 0, 0, 0, 0);
        tick(); idle(); e_valid = 1; e_branch = 3'b100; push("ret_run", 2'b01, 1, 0, 0, 0, 0);

        // interrupt injection latency
        tick(); idle(); irq = 1; push("irq_c0", 2'b00, 0, 0, 0, 0, 0);
        tick(); irq = 0; push("irq_c1", 2'b00, 0, 0, 0, 0, 0);
        tick(); push("irq_c2", 2'b00, 0, 0, 0, 0, 0);
        tick(); push("inject", 2'b00, 0, 0, 1, 1, 0);
        tick(); push("int_wait", 2'b00, 0, 0, 0, 0, 0);
        tick(); e_valid = 1; e_int = 1; push("int_e", 2'b11, 1, 0, 0, 0, 0);
        tick(); idle(); push("int_done", 2'b00, 0, 0, 0, 0, 0);
        tick(); push("no_reinj", 2'b00, 0, 0, 0, 0, 0);

        // injected INT flushed by an older jump, then re-injected
        ack0 = ack_cnt; vec0 = vec_cnt;
        tick(); irq = 1; push("irq2_c0", 2'b00, 0, 0, 0, 0, 0);
        tick(); irq = 0; push("irq2_c1", 2'b00, 0, 0, 0, 0, 0);
        tick(); push("irq2_c2", 2'b00, 0, 0, 0, 0, 0);
        tick(); push("inj1", 2'b00, 0, 0, 1, 1, 0);
        tick(); e_valid = 1; e_branch = 3'b100; push("jmp_over", 2'b01, 1, 0, 0, 0, 0);
        tick(); idle(); push("inj2", 2'b00, 0, 0, 1, 1, 0);
        tick(); push("int_wait2", 2'b00, 0, 0, 0, 0, 0);
        tick(); e_valid = 1; e_int = 1; push("int_e2", 2'b11, 1, 0, 0, 0, 0);
        tick(); idle(); push("int_done2", 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        check("ack_pulses", 32'(ack_cnt - ack0), 32'd2);
        check("vec_redirects", 32'(vec_cnt - vec0), 32'd1);

        // halt and wake by interrupt
        tick(); e_valid = 1; e_hlt = 1; push("hlt", 2'b00, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(); idle(); push("halt_hold", 2'b00, 0, 1, 0, 0, 1);
        end
        tick(); irq = 1; push("halt_irq0", 2'b00, 0, 1, 0, 0, 1);
        tick(); irq = 0; push("halt_irq1", 2'b00, 0, 1, 0, 0, 1);
        tick(); push("halt_irq2", 2'b00, 0, 1, 0, 0, 1);
        tick(); push("halt_wake", 2'b00, 0, 0, 1, 1, 1);
        tick(); push("unhalted", 2'b00, 0, 0, 0, 0, 0);
        tick(); e_valid = 1; e_int = 1; push("halt_int_e", 2'b11, 1, 0, 0, 0, 0);

        // asynchronous reset while waiting for a return
        tick(); idle(); e_valid = 1; e_ret = 1; push("ret2", 2'b00, 1, 1, 0, 0, 0);
        tick(); idle(); push("ret2_wait", 2'b00, 0, 1, 0, 0, 0);
        tick(); push("ret2_pre", 2'b00, 0, 0, 0, 0, 0);
        #1 rst_n = 0;
        #1 check("arst_async", 32'(outs()), 32'd0);
        tick(); rst_n = 1; push("arst_rel", 2'b00, 0, 0, 0, 0, 0);
        tick(); m_ret_done = 1; push("ret_discard", 2'b00, 0, 0, 0, 0, 0);

        tick(); idle();
        @(negedge clk); #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
